fwd_hazard_unit: RTL and testbench

Forwarding and load-use hazard controller for the 5-stage pipelined CPU. It tracks destination-register and control bits for the instructions in the EX, MEM and WB stages in its own shadow pipeline. It drives the 2-bit operand-select inputs of the EX-stage operand muxes, which are trees of 2:1 muxes fed by register-file data, the EX/MEM ALU result and the WB write data. It also raises the load-use stall that freezes PC and IF/ID.

---
 rtl/fwd_hazard_unit_if.sv | 29 ++
 rtl/fwd_hazard_unit.sv | 111 +++++++++++
 tb/tb_fwd_hazard_unit.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/fwd_hazard_unit_if.sv
// ID-stage instruction fields into the forwarding/hazard unit and its
// operand-select, stall and statistics outputs back to the pipeline.
interface fwd_hazard_unit_if #(
    parameter int REG_BITS = 5,
    parameter int CNT_BITS = 16
);
    logic [REG_BITS-1:0] id_rn;
    logic [REG_BITS-1:0] id_rm;
    logic [REG_BITS-1:0] id_rd;
    logic                id_use_rn;
    logic                id_use_rm;
    logic                id_reg_write;
    logic                id_mem_read;
    logic                flush;
    logic [1:0]          fwd_a;
    logic [1:0]          fwd_b;
    logic                stall;
    logic [CNT_BITS-1:0] stall_cnt;

    modport master (
        output id_rn, id_rm, id_rd, id_use_rn, id_use_rm, id_reg_write, id_mem_read, flush,
        input  fwd_a, fwd_b, stall, stall_cnt
    );

    modport slave (
        input  id_rn, id_rm, id_rd, id_use_rn, id_use_rm, id_reg_write, id_mem_read, flush,
        output fwd_a, fwd_b, stall, stall_cnt
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard controller: shadows rd/control bits of the
// EX, MEM and WB instructions and drives EX operand selects and the stall.
module fwd_hazard_unit #(
    parameter int REG_BITS = 5,
    parameter int ZERO_REG = 31,
    parameter int CNT_BITS = 16
) (
    input logic               clk,
    input logic               reset,
    fwd_hazard_unit_if.slave  bus
);
    localparam logic [REG_BITS-1:0] ZERO = REG_BITS'(ZERO_REG);

    logic [REG_BITS-1:0] ex_rd_q, ex_rd_d, ex_rn_q, ex_rn_d, ex_rm_q, ex_rm_d;
    logic                ex_use_rn_q, ex_use_rn_d, ex_use_rm_q, ex_use_rm_d;
    logic                ex_reg_write_q, ex_reg_write_d, ex_mem_read_q, ex_mem_read_d;
    logic [REG_BITS-1:0] mem_rd_q, mem_rd_d, wb_rd_q, wb_rd_d;
    logic                mem_reg_write_q, mem_reg_write_d, wb_reg_write_q, wb_reg_write_d;
    logic [CNT_BITS-1:0] stall_cnt_q, stall_cnt_d;
    logic                hazard;
    logic                stall;

    // MEM holds the younger producer, so it is checked before WB.
    function automatic logic [1:0] fwd_sel(
        input logic                use_src,
        input logic [REG_BITS-1:0] src,
        input logic                mem_wr,
        input logic [REG_BITS-1:0] mem_rd,
        input logic                wb_wr,
        input logic [REG_BITS-1:0] wb_rd
    );
        if (!use_src || src == ZERO) return 2'b00;
        if (mem_wr && mem_rd == src) return 2'b01;
        if (wb_wr && wb_rd == src)   return 2'b10;
        return 2'b00;
    endfunction

    always_comb begin
        hazard = ex_mem_read_q && ex_reg_write_q && (ex_rd_q != ZERO) &&
                 ((bus.id_use_rn && bus.id_rn == ex_rd_q) ||
                  (bus.id_use_rm && bus.id_rm == ex_rd_q));
        // Gated by reset so the stall never reflects ID inputs while in reset.
        stall = hazard && !bus.flush && reset;
    end

    assign bus.stall     = stall;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.fwd_a = fwd_sel(ex_use_rn_q, ex_rn_q, mem_reg_write_q, mem_rd_q,
                               wb_reg_write_q, wb_rd_q);
    assign bus.fwd_b = fwd_sel(ex_use_rm_q, ex_rm_q, mem_reg_write_q, mem_rd_q,
                               wb_reg_write_q, wb_rd_q);

    always_comb begin
        mem_rd_d        = ex_rd_q;
        mem_reg_write_d = ex_reg_write_q;
        wb_rd_d         = mem_rd_q;
        wb_reg_write_d  = mem_reg_write_q;

        ex_rd_d        = ZERO;
        ex_rn_d        = ZERO;
        ex_rm_d        = ZERO;
        ex_use_rn_d    = 1'b0;
        ex_use_rm_d    = 1'b0;
        ex_reg_write_d = 1'b0;
        ex_mem_read_d  = 1'b0;
        if (!stall && !bus.flush) begin
            ex_rd_d        = bus.id_rd;
            ex_rn_d        = bus.id_rn;
            ex_rm_d        = bus.id_rm;
            ex_use_rn_d    = bus.id_use_rn;
            ex_use_rm_d    = bus.id_use_rm;
            ex_reg_write_d = bus.id_reg_write;
            ex_mem_read_d  = bus.id_mem_read;
        end

        stall_cnt_d = stall_cnt_q;
        if (stall && stall_cnt_q != {CNT_BITS{1'b1}}) begin
            stall_cnt_d = stall_cnt_q + CNT_BITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ex_rd_q         <= ZERO;
            ex_rn_q         <= ZERO;
            ex_rm_q         <= ZERO;
            ex_use_rn_q     <= 1'b0;
            ex_use_rm_q     <= 1'b0;
            ex_reg_write_q  <= 1'b0;
            ex_mem_read_q   <= 1'b0;
            mem_rd_q        <= ZERO;
            mem_reg_write_q <= 1'b0;
            wb_rd_q         <= ZERO;
            wb_reg_write_q  <= 1'b0;
            stall_cnt_q     <= '0;
        end else begin
            ex_rd_q         <= ex_rd_d;
            ex_rn_q         <= ex_rn_d;
            ex_rm_q         <= ex_rm_d;
            ex_use_rn_q     <= ex_use_rn_d;
            ex_use_rm_q     <= ex_use_rm_d;
            ex_reg_write_q  <= ex_reg_write_d;
            ex_mem_read_q   <= ex_mem_read_d;
            mem_rd_q        <= mem_rd_d;
            mem_reg_write_q <= mem_reg_write_d;
            wb_rd_q         <= wb_rd_d;
            wb_reg_write_q  <= wb_reg_write_d;
            stall_cnt_q     <= stall_cnt_d;
        end
    end
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: instruction sequences with hand-derived expected
// selects/stall queued per cycle; a second instance checks counter saturation.
module tb_fwd_hazard_unit;
    logic clk = 1'b0;
    logic reset;

    fwd_hazard_unit_if #(.REG_BITS(5), .CNT_BITS(16)) ifc ();
    fwd_hazard_unit_if #(.REG_BITS(5), .CNT_BITS(2))  ifs ();

    fwd_hazard_unit #(.REG_BITS(5), .ZERO_REG(31), .CNT_BITS(16)) dut (
        .clk(clk), .reset(reset), .bus(ifc)
    );
    fwd_hazard_unit #(.REG_BITS(5), .ZERO_REG(31), .CNT_BITS(2)) dut_sat (
        .clk(clk), .reset(reset), .bus(ifs)
    );

    assign ifs.id_rn        = ifc.id_rn;
    assign ifs.id_rm        = ifc.id_rm;
    assign ifs.id_rd        = ifc.id_rd;
    assign ifs.id_use_rn    = ifc.id_use_rn;
    assign ifs.id_use_rm    = ifc.id_use_rm;
    assign ifs.id_reg_write = ifc.id_reg_write;
    assign ifs.id_mem_read  = ifc.id_mem_read;
    assign ifs.flush        = ifc.flush;

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        st;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_cnt  = '0;
    logic [1:0]  exp_cnt2 = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check({e.tag, ".fwd_a"},     32'(ifc.fwd_a),     32'(e.fa));
            check({e.tag, ".fwd_b"},     32'(ifc.fwd_b),     32'(e.fb));
            check({e.tag, ".stall"},     32'(ifc.stall),     32'(e.st));
            check({e.tag, ".cnt"},       32'(ifc.stall_cnt), 32'(e.cnt));
            check({e.tag, ".cnt_sat"},   32'(ifs.stall_cnt), 32'(e.cnt2));
            check({e.tag, ".stall_sat"}, 32'(ifs.stall),     32'(e.st));
        end
    end

    // One ID cycle: drive fields after the edge, queue what the DUT must show this cycle.
    task automatic step(input string tag, input logic rst_n,
                        input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm,
                        input logic urn, input logic urm, input logic rw, input logic mr,
                        input logic fl, input logic [1:0] ea, input logic [1:0] eb,
                        input logic est);
        exp_t e;
        @(posedge clk);
        #1;
        reset            = rst_n;
        ifc.id_rd        = rd;
        ifc.id_rn        = rn;
        ifc.id_rm        = rm;
        ifc.id_use_rn    = urn;
        ifc.id_use_rm    = urm;
        ifc.id_reg_write = rw;
        ifc.id_mem_read  = mr;
        ifc.flush        = fl;
        e.tag  = tag;
        e.fa   = ea;
        e.fb   = eb;
        e.st   = est;
        e.cnt  = exp_cnt;
        e.cnt2 = exp_cnt2;
        sb_q.push_back(e);
        if (!rst_n) begin
            exp_cnt  = '0;
            exp_cnt2 = '0;
        end else if (est) begin
            if (exp_cnt != 16'hffff) exp_cnt++;
            if (exp_cnt2 != 2'd3)    exp_cnt2++;
        end
    endtask

    task automatic alu(input string tag, input logic [4:0] rd, input logic [4:0] rn,
                       input logic [4:0] rm, input logic [1:0] ea, input logic [1:0] eb,
                       input logic est);
        step(tag, 1'b1, rd, rn, rm, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ea, eb, est);
    endtask

    task automatic ldr(input string tag, input logic [4:0] rd, input logic [4:0] rn,
                       input logic [1:0] ea, input logic [1:0] eb, input logic est);
        step(tag, 1'b1, rd, rn, 5'd31, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, ea, eb, est);
    endtask

    task automatic nop(input string tag, input logic [1:0] ea, input logic [1:0] eb);
        step(tag, 1'b1, 5'd31, 5'd31, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ea, eb, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset            = 1'b0;
        ifc.id_rd        = 5'($urandom);
        ifc.id_rn        = 5'($urandom);
        ifc.id_rm        = 5'($urandom);
        ifc.id_use_rn    = 1'b1;
        ifc.id_use_rm    = 1'b1;
        ifc.id_reg_write = 1'b1;
        ifc.id_mem_read  = 1'b1;
        ifc.flush        = 1'b0;

        // Second reset cycle with random ID inputs: slots already bubbles
        step("rst", 1'b0, 5'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b1, 1'b1, 1'b1,
             1'b0, 2'b00, 2'b00, 1'b0);

        // Distance 1 -> 01
        alu("d1_prod", 5'd1, 5'd4, 5'd5, 2'b00, 2'b00, 1'b0);
        alu("d1_cons", 5'd6, 5'd1, 5'd7, 2'b00, 2'b00, 1'b0);
        nop("d1_ex",   2'b01, 2'b00);
        nop("d1_gap",  2'b00, 2'b00);
        // Distance 2 -> 10
        alu("d2_prod", 5'd1, 5'd4, 5'd5, 2'b00, 2'b00, 1'b0);
        nop("d2_n1",   2'b00, 2'b00);
        alu("d2_cons", 5'd8, 5'd1, 5'd7, 2'b00, 2'b00, 1'b0);
        nop("d2_ex",   2'b10, 2'b00);
        // Distance 3 -> 00
        alu("d3_prod", 5'd1, 5'd4, 5'd5, 2'b00, 2'b00, 1'b0);
        nop("d3_n1",   2'b00, 2'b00);
        nop("d3_n2",   2'b00, 2'b00);
        alu("d3_cons", 5'd9, 5'd1, 5'd7, 2'b00, 2'b00, 1'b0);
        nop("d3_ex",   2'b00, 2'b00);
        // Two producers of X2: MEM wins
        alu("dp_p2",   5'd2, 5'd4, 5'd5, 2'b00, 2'b00, 1'b0);
        alu("dp_p1",   5'd2, 5'd4, 5'd5, 2'b00, 2'b00, 1'b0);
        alu("dp_cons", 5'd10, 5'd7, 5'd2, 2'b00, 2'b00, 1'b0);
        nop("dp_ex",   2'b00, 2'b01);
        // Zero register never forwards or stalls
        alu("z_prod",  5'd31, 5'd4, 5'd5, 2'b00, 2'b00, 1'b0);
        alu("z_cons",  5'd11, 5'd31, 5'd31, 2'b00, 2'b00, 1'b0);
        nop("z_ex",    2'b00, 2'b00);
        ldr("z_ld",    5'd31, 5'd4, 2'b00, 2'b00, 1'b0);
        alu("z_ldcons", 5'd12, 5'd31, 5'd31, 2'b00, 2'b00, 1'b0);
        nop("z_ldex",  2'b00, 2'b00);
        // Load-use on rn: one stall, then WB forward
        ldr("lu_ld",   5'd3, 5'd4, 2'b00, 2'b00, 1'b0);
        alu("lu_haz",  5'd13, 5'd3, 5'd7, 2'b00, 2'b00, 1'b1);
        alu("lu_hold", 5'd13, 5'd3, 5'd7, 2'b00, 2'b00, 1'b0);
        nop("lu_ex",   2'b10, 2'b00);
        // Flush in the hazard cycle: no stall, counter unchanged
        ldr("fl_ld",   5'd3, 5'd4, 2'b00, 2'b00, 1'b0);
        step("fl_haz", 1'b1, 5'd13, 5'd3, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1,
             2'b00, 2'b00, 1'b0);
        nop("fl_ex",   2'b00, 2'b00);
        // Load-use on rm
        ldr("lr_ld",   5'd14, 5'd4, 2'b00, 2'b00, 1'b0);
        alu("lr_haz",  5'd15, 5'd7, 5'd14, 2'b00, 2'b00, 1'b1);
        alu("lr_hold", 5'd15, 5'd7, 5'd14, 2'b00, 2'b00, 1'b0);
        nop("lr_ex",   2'b00, 2'b10);
        // Back-to-back dependent loads, then a consumer of the second
        ldr("cl_ld1",  5'd3, 5'd4, 2'b00, 2'b00, 1'b0);
        ldr("cl_ld2",  5'd5, 5'd3, 2'b00, 2'b00, 1'b1);
        ldr("cl_hold", 5'd5, 5'd3, 2'b00, 2'b00, 1'b0);
        alu("cl_cons", 5'd16, 5'd5, 5'd7, 2'b10, 2'b00, 1'b1);
        alu("cl_chold", 5'd16, 5'd5, 5'd7, 2'b00, 2'b00, 1'b0);
        nop("cl_ex",   2'b10, 2'b00);
        // Fifth stall: saturated instance stays at 3
        ldr("s5_ld",   5'd3, 5'd4, 2'b00, 2'b00, 1'b0);
        alu("s5_haz",  5'd17, 5'd3, 5'd3, 2'b00, 2'b00, 1'b1);
        alu("s5_hold", 5'd17, 5'd3, 5'd3, 2'b00, 2'b00, 1'b0);
        nop("s5_ex",   2'b10, 2'b10);
        // Unused source field matching a load never stalls or forwards
        ldr("un_ld",   5'd3, 5'd4, 2'b00, 2'b00, 1'b0);
        step("un_cons", 1'b1, 5'd19, 5'd3, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
             2'b00, 2'b00, 1'b0);
        nop("un_ex",   2'b00, 2'b00);
        // Reset mid-operation with a pending load-use
        ldr("mr_ld",   5'd3, 5'd4, 2'b00, 2'b00, 1'b0);
        step("mr_rst1", 1'b0, 5'd18, 5'd3, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
             2'b00, 2'b00, 1'b0);
        step("mr_rst2", 1'b0, 5'd18, 5'd3, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
             2'b00, 2'b00, 1'b0);
        alu("mr_cons", 5'd18, 5'd3, 5'd7, 2'b00, 2'b00, 1'b0);
        nop("mr_ex",   2'b00, 2'b00);

        @(posedge clk);
        #1;
        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
